dtcm_port_arb: RTL and testbench

Two-requester arbiter for the single-port DTCM SRAM. It sits between the core data-memory port (`data_dtcm_*` from the MEM stage) and the external slave port (`ext_*`, fed by the AHB-slave/DMA bridge), and owns the SRAM macro pins. It does single-beat, fixed-priority arbitration with an optional anti-starvation override. It also routes the one-cycle-latency read data back to whichever requester issued the read.

---
 rtl/dtcm_port_arb_pkg.sv | 17 +
 rtl/dtcm_port_arb.sv | 132 +++++++++++++
 tb/tb_dtcm_port_arb.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/dtcm_port_arb_pkg.sv
// Shared defaults and FSM encoding for the DTCM port arbiter.
// DTCM_SIZE (bytes) may be predefined by the build; it sets the default SRAM word-address width.
`ifndef DTCM_SIZE
`define DTCM_SIZE 16384
`endif

package dtcm_port_arb_pkg;

    localparam int unsigned DTCM_AW_DEFAULT  = $clog2(`DTCM_SIZE) - 2;
    localparam int unsigned MAX_WAIT_DEFAULT = 8;

    typedef enum logic {
        PRI_CORE  = 1'b0,
        FORCE_EXT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/dtcm_port_arb.sv
// Single-beat fixed-priority arbiter between the core and external ports of the DTCM SRAM.
// Anti-starvation override for the ext port is built only when DTCM_ARB_ANTI_STARVE_EN is defined.
module dtcm_port_arb
    import dtcm_port_arb_pkg::*;
#(
    parameter int unsigned DTCM_AW  = DTCM_AW_DEFAULT,
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic               cpu_clk,
    input  logic               cpu_rstn,

    input  logic               core_access,
    output logic               core_ready,
    input  logic               core_rd0_wr1,
    input  logic [3:0]         core_byte_strobe,
    input  logic [DTCM_AW+1:0] core_addr,
    input  logic [31:0]        core_write_data,
    output logic [31:0]        core_read_data,
    output logic               core_read_data_valid,

    input  logic               ext_access,
    output logic               ext_ready,
    input  logic               ext_rd0_wr1,
    input  logic [3:0]         ext_byte_strobe,
    input  logic [DTCM_AW+1:0] ext_addr,
    input  logic [31:0]        ext_write_data,
    output logic [31:0]        ext_read_data,
    output logic               ext_read_data_valid,

    output logic               ram_cs,
    output logic               ram_we,
    output logic [3:0]         ram_be,
    output logic [DTCM_AW-1:0] ram_addr,
    output logic [31:0]        ram_wdata,
    input  logic [31:0]        ram_rdata
);

    logic force_ext;
    logic grant_core;
    logic grant_ext;
    logic rd_pend_q;
    logic rd_owner_q;

    // Byte-offset bits are implied by the word-wide SRAM.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^{core_addr[1:0], ext_addr[1:0]};

    assign grant_core = core_access && !force_ext;
    assign grant_ext  = ext_access && (!core_access || force_ext);
    assign core_ready = grant_core;
    assign ext_ready  = grant_ext;

`ifdef DTCM_ARB_ANTI_STARVE_EN
    arb_state_e state_q, state_d;
    logic [3:0] starve_cnt_q, starve_cnt_d;

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!ext_access || grant_ext) begin
            starve_cnt_d = 4'd0;
        end else if (starve_cnt_q != 4'(MAX_WAIT)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            state_q      <= PRI_CORE;
            starve_cnt_q <= 4'd0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // Switch as the counter reaches the limit so ext wins on the very next stall cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            PRI_CORE:  if (starve_cnt_d == 4'(MAX_WAIT)) state_d = FORCE_EXT;
            FORCE_EXT: if (grant_ext || !ext_access) state_d = PRI_CORE;
            default:   state_d = PRI_CORE;
        endcase
    end

    always_comb begin
        force_ext = 1'b0;
        if (state_q == FORCE_EXT) force_ext = ext_access;
    end
`else
    logic [3:0] unused_max_wait;
    assign unused_max_wait = 4'(MAX_WAIT);
    assign force_ext       = 1'b0;
`endif

    always_comb begin
        ram_cs    = grant_core | grant_ext;
        ram_we    = 1'b0;
        ram_be    = 4'd0;
        ram_addr  = '0;
        ram_wdata = 32'd0;
        if (grant_core) begin
            ram_we    = core_rd0_wr1;
            ram_be    = core_byte_strobe;
            ram_addr  = core_addr[DTCM_AW+1:2];
            ram_wdata = core_write_data;
        end else if (grant_ext) begin
            ram_we    = ext_rd0_wr1;
            ram_be    = ext_byte_strobe;
            ram_addr  = ext_addr[DTCM_AW+1:2];
            ram_wdata = ext_write_data;
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            rd_pend_q  <= 1'b0;
            rd_owner_q <= 1'b0;
        end else begin
            rd_pend_q  <= ram_cs && !ram_we;
            rd_owner_q <= grant_ext;
        end
    end

    always_comb begin
        core_read_data_valid = rd_pend_q && !rd_owner_q;
        ext_read_data_valid  = rd_pend_q && rd_owner_q;
        core_read_data       = core_read_data_valid ? ram_rdata : 32'd0;
        ext_read_data        = ext_read_data_valid ? ram_rdata : 32'd0;
    end

endmodule

// File: tb/tb_dtcm_port_arb.sv
// Directed self-checking bench for dtcm_port_arb; starvation expectations follow
// whether DTCM_ARB_ANTI_STARVE_EN is defined for the build.
module tb_dtcm_port_arb;

    localparam int unsigned AW = 12;

    logic          cpu_clk = 1'b0;
    logic          cpu_rstn;
    logic          core_access, core_ready, core_rd0_wr1, core_read_data_valid;
    logic [3:0]    core_byte_strobe;
    logic [AW+1:0] core_addr;
    logic [31:0]   core_write_data, core_read_data;
    logic          ext_access, ext_ready, ext_rd0_wr1, ext_read_data_valid;
    logic [3:0]    ext_byte_strobe;
    logic [AW+1:0] ext_addr;
    logic [31:0]   ext_write_data, ext_read_data;
    logic          ram_cs, ram_we;
    logic [3:0]    ram_be;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata, ram_rdata;

    int checks = 0;
    int errors = 0;

    dtcm_port_arb #(.DTCM_AW(AW), .MAX_WAIT(8)) dut (
        .cpu_clk              (cpu_clk),
        .cpu_rstn             (cpu_rstn),
        .core_access          (core_access),
        .core_ready           (core_ready),
        .core_rd0_wr1         (core_rd0_wr1),
        .core_byte_strobe     (core_byte_strobe),
        .core_addr            (core_addr),
        .core_write_data      (core_write_data),
        .core_read_data       (core_read_data),
        .core_read_data_valid (core_read_data_valid),
        .ext_access           (ext_access),
        .ext_ready            (ext_ready),
        .ext_rd0_wr1          (ext_rd0_wr1),
        .ext_byte_strobe      (ext_byte_strobe),
        .ext_addr             (ext_addr),
        .ext_write_data       (ext_write_data),
        .ext_read_data        (ext_read_data),
        .ext_read_data_valid  (ext_read_data_valid),
        .ram_cs               (ram_cs),
        .ram_we               (ram_we),
        .ram_be               (ram_be),
        .ram_addr             (ram_addr),
        .ram_wdata            (ram_wdata),
        .ram_rdata            (ram_rdata)
    );

    always #5 cpu_clk = ~cpu_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic next_cycle();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic idle_inputs();
        core_access = 1'b0; core_rd0_wr1 = 1'b0; core_byte_strobe = 4'hf;
        core_addr = '0; core_write_data = 32'd0;
        ext_access = 1'b0; ext_rd0_wr1 = 1'b0; ext_byte_strobe = 4'hf;
        ext_addr = '0; ext_write_data = 32'd0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_outs"}, {ram_wdata}, 32'd0);
        check_eq({tag, "_ctl"},
                 {20'd0, ram_cs, ram_we, ram_be, core_ready, ext_ready,
                  core_read_data_valid, ext_read_data_valid, 2'd0}, 32'd0);
        check_eq({tag, "_addr"}, {20'd0, ram_addr}, 32'd0);
        check_eq({tag, "_rdata"}, core_read_data | ext_read_data, 32'd0);
    endtask

    initial begin
        cpu_rstn  = 1'b0;
        ram_rdata = 32'h5555_aaaa;
        idle_inputs();
        #2;
        check_all_zero("reset");
        core_access = 1'b1;
        #1;
        check_eq("reset_core_ready_follows", {31'd0, core_ready}, 32'd1);
        check_eq("reset_ram_cs", {31'd0, ram_cs}, 32'd1);
        core_access = 1'b0;
        next_cycle();
        next_cycle();
        cpu_rstn = 1'b1;
        next_cycle();

        // Core-only read.
        core_access = 1'b1; core_addr = 14'h010;
        #1;
        check_eq("rd_ram_addr", {20'd0, ram_addr}, 32'd4);
        check_eq("rd_cs_we", {30'd0, ram_cs, ram_we}, 32'b10);
        check_eq("rd_core_ready", {31'd0, core_ready}, 32'd1);
        next_cycle();
        idle_inputs();
        ram_rdata = 32'hdead_beef;
        #1;
        check_eq("rd_core_valid", {31'd0, core_read_data_valid}, 32'd1);
        check_eq("rd_core_data", core_read_data, 32'hdead_beef);
        check_eq("rd_ext_valid", {31'd0, ext_read_data_valid}, 32'd0);
        check_eq("rd_ext_data", ext_read_data, 32'd0);
        check_eq("rd_idle_cs", {31'd0, ram_cs}, 32'd0);

        // Simultaneous core write and ext read.
        next_cycle();
        core_access = 1'b1; core_rd0_wr1 = 1'b1; core_byte_strobe = 4'b0011;
        core_addr = 14'h020; core_write_data = 32'h1234;
        ext_access = 1'b1; ext_addr = 14'h044;
        #1;
        check_eq("sim_ready", {30'd0, core_ready, ext_ready}, 32'b10);
        check_eq("sim_we_be", {27'd0, ram_we, ram_be}, 32'b1_0011);
        check_eq("sim_wdata", ram_wdata, 32'h1234);
        check_eq("sim_waddr", {20'd0, ram_addr}, 32'd8);
        next_cycle();
        core_access = 1'b0; core_rd0_wr1 = 1'b0;
        #1;
        check_eq("sim_ext_ready", {30'd0, core_ready, ext_ready}, 32'b01);
        check_eq("sim_ext_addr", {20'd0, ram_addr}, 32'h11);
        check_eq("sim_write_no_valid", {30'd0, core_read_data_valid, ext_read_data_valid}, 32'd0);
        next_cycle();
        ext_access = 1'b0;
        ram_rdata = 32'hcafe_f00d;
        #1;
        check_eq("sim_valids", {30'd0, core_read_data_valid, ext_read_data_valid}, 32'b01);
        check_eq("sim_ext_data", ext_read_data, 32'hcafe_f00d);
        check_eq("sim_core_data", core_read_data, 32'd0);
        next_cycle();
        check_eq("sim_single_pulse", {31'd0, ext_read_data_valid}, 32'd0);

        // Alternating back-to-back reads: core, ext, core.
        idle_inputs();
        core_access = 1'b1; core_addr = 14'h100;
        next_cycle();
        core_access = 1'b0; ext_access = 1'b1; ext_addr = 14'h200;
        ram_rdata = 32'h1111_1111;
        #1;
        check_eq("alt1_valids", {30'd0, core_read_data_valid, ext_read_data_valid}, 32'b10);
        check_eq("alt1_data", core_read_data ^ ext_read_data, 32'h1111_1111);
        check_eq("alt1_addr", {20'd0, ram_addr}, 32'h80);
        next_cycle();
        ext_access = 1'b0; core_access = 1'b1; core_addr = 14'h300;
        ram_rdata = 32'h2222_2222;
        #1;
        check_eq("alt2_valids", {30'd0, core_read_data_valid, ext_read_data_valid}, 32'b01);
        check_eq("alt2_ext_data", ext_read_data, 32'h2222_2222);
        check_eq("alt2_core_data", core_read_data, 32'd0);
        next_cycle();
        core_access = 1'b0;
        ram_rdata = 32'h3333_3333;
        #1;
        check_eq("alt3_valids", {30'd0, core_read_data_valid, ext_read_data_valid}, 32'b10);
        check_eq("alt3_core_data", core_read_data, 32'h3333_3333);
        check_eq("alt3_ext_data", ext_read_data, 32'd0);

        // Starvation: both requesters held for 20 cycles.
        next_cycle();
        core_access = 1'b1; core_addr = 14'h000;
        ext_access = 1'b1; ext_addr = 14'h004;
        for (int i = 0; i < 20; i++) begin
            logic exp_ext;
`ifdef DTCM_ARB_ANTI_STARVE_EN
            exp_ext = (i == 8) || (i == 17);
`else
            exp_ext = 1'b0;
`endif
            #1;
            check_eq($sformatf("starve_c%0d", i), {30'd0, core_ready, ext_ready},
                     {30'd0, !exp_ext, exp_ext});
            next_cycle();
        end
        idle_inputs();

        // Reset asserted in the cycle after an accepted core read.
        next_cycle();
        core_access = 1'b1; core_addr = 14'h040;
        next_cycle();
        core_access = 1'b0;
        cpu_rstn = 1'b0;
        ram_rdata = 32'h7777_7777;
        #1;
        check_eq("rst_mid_no_valid", {31'd0, core_read_data_valid}, 32'd0);
        check_eq("rst_mid_data", core_read_data, 32'd0);
        next_cycle();
        cpu_rstn = 1'b1;
        next_cycle();
        #1;
        check_all_zero("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
